ysyx_22050612_mem_responder: RTL and testbench
==============================================

// Module: ysyx_22050612_mem_responder
// PURPOSE
//   Memory-side responder for the core's load/store port: accepts one request at a time
//   (read, or byte-masked write), waits a fixed latency, then returns data/ack on a
//   valid/ready response channel. Backed by an internal 64-bit-wide word array.
//   Sits between the execute/LSU initiator and on-chip data storage; replaces DPI pmem access.
// PARAMETERS
//   DEPTH   1024         number of 64-bit words (power of two)
//   AW      10           log2(DEPTH), word-index width
//   LAT     2            cycles from request accept to resp_valid (legal range 1..15)
//   BASE    64'h80000000 byte address mapped to word 0
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   asynchronous, active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept (high only in IDLE)
//   req_we      in   1   1 = write, 0 = read
//   req_addr    in   64  byte address; bits [2:0] ignored (word access)
//   req_wdata   in   64  write data, lane-aligned
//   req_wmask   in   8   byte-enable, bit i -> wdata[8i+7:8i]
//   resp_valid  out  1   response present
//   resp_ready  in   1   initiator accepts response
//   resp_rdata  out  64  read data (full word); 0 for write responses
//   resp_err    out  1   out-of-range flag (only with MEM_RESP_RANGE_CHK_EN, else tied 0)
// BEHAVIOUR
//   - Reset (async, any cycle): state=IDLE, lat_cnt=0, resp_valid=0, resp_rdata=0,
//     resp_err=0; req_ready=1 after reset releases. Array contents NOT reset.
//   - States: IDLE -> BUSY -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid at edge: latch we/addr/wdata/wmask, lat_cnt=LAT-1,
//       go BUSY. Request inputs are ignored outside IDLE.
//     BUSY: lat_cnt decrements each edge; at the edge where lat_cnt==0: perform access
//       (write: update masked bytes; read: capture word into resp_rdata), set resp_valid=1,
//       go RESP. Accept at edge T -> resp_valid high after edge T+LAT.
//     RESP: hold resp_valid/resp_rdata/resp_err stable until resp_ready; on handshake edge
//       clear resp_valid, resp_rdata=0, resp_err=0, go IDLE. Next request accepted no
//       earlier than the following edge (no overlap; max throughput 1 per LAT+2 cycles).
//   - Word index = (addr - BASE)[AW+2:3]; subtraction mod 2^64. Without range check,
//     out-of-window addresses alias modulo DEPTH.
//   - Write with wmask=0: no array change, still gets a response. Write response rdata=0.
//   - Write commits at end of BUSY, so a read accepted after a write's response always
//     returns the written data; read-after-write to same word needs no forwarding.
//   - Reset during BUSY: pending write is discarded (array unchanged); during RESP: response lost.
// CONFIGURATION
//   `MEM_RESP_RANGE_CHK_EN defined: if (addr - BASE) >= DEPTH*8, read returns rdata=0 with
//     resp_err=1, write is suppressed with resp_err=1; latency and handshake unchanged.
//   Not defined: no check, aliasing as above, resp_err constant 0.
// STRUCTURE
//   Package ysyx_22050612_mem_pkg: state enum {IDLE,BUSY,RESP}, XLEN=64, MASKW=8, BASE default.
//   Sub-module ysyx_22050612_mem_array: DEPTH x 64 storage, synchronous byte-masked write,
//     synchronous read, single port (one access per cycle); FSM/counter stay in top.
// TESTING
//   1 Reset: assert rst mid-run -> resp_valid=0, resp_rdata=0, req_ready=1 after release.
//   2 Write 0x1122334455667788 @0x80000010 mask 0xFF, then read @0x80000010 -> rdata
//     0x1122334455667788, resp_valid exactly LAT cycles after each accept (LAT=2 and LAT=1).
//   3 Partial write wdata 0xAB00_0000_0000_0000 mask 0x80 over prior word -> read gives
//     0xAB22334455667788.
//   4 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0
//     throughout; new req_valid ignored until handshake completes.
//   5 Reset asserted during BUSY of a write to 0x80000018 -> subsequent read returns old value.
//   6 Range: read @0x7FFFFFF8 -> with MEM_RESP_RANGE_CHK_EN resp_err=1, rdata=0; without it
//     rdata equals word at index DEPTH-1, resp_err=0.

Source files
------------

// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types and constants for the load/store memory responder.
package ysyx_22050612_mem_pkg;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned MASKW = 8;
  localparam logic [63:0] MEM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;
endpackage

// File: rtl/ysyx_22050612_mem_array.sv
// Single-port DEPTH x 64 storage: synchronous byte-masked write, registered read.
module ysyx_22050612_mem_array
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [XLEN-1:0]  wdata,
  input  logic [MASKW-1:0] wmask,
  output logic [XLEN-1:0]  rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  // rdata only changes on a read access, so it holds across the response phase
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < MASKW; i++) begin
          if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/ysyx_22050612_mem_responder.sv
// Fixed-latency memory responder for the core load/store port.
// Optional out-of-range checking is enabled by defining MEM_RESP_RANGE_CHK_EN.
module ysyx_22050612_mem_responder
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned LAT   = 2,
  parameter logic [63:0] BASE  = MEM_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [63:0]      req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [MASKW-1:0] req_wmask,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_err
);
  localparam logic [3:0] LAT_INIT = 4'(LAT - 1);

  state_t           state, next_state;
  logic [3:0]       lat_cnt;
  logic             we_q, oor_q, rd_hold, err_q, access;
  logic [AW-1:0]    idx_q;
  logic [XLEN-1:0]  wdata_q, arr_rdata;
  logic [MASKW-1:0] wmask_q;
  logic [63:0]      offset;
  logic [AW-1:0]    req_idx;
  logic             req_oor;

  assign offset  = req_addr - BASE;
  assign req_idx = offset[AW+2:3];

`ifdef MEM_RESP_RANGE_CHK_EN
  logic unused_offset;
  assign unused_offset = ^offset[2:0];
  assign req_oor = |offset[63:AW+3];
`else
  logic unused_offset;
  assign unused_offset = ^{offset[63:AW+3], offset[2:0]};
  assign req_oor = 1'b0;
`endif

  always_comb begin
    next_state = state;
    access     = 1'b0;
    case (state)
      IDLE: if (req_valid) next_state = BUSY;
      BUSY: if (lat_cnt == 4'd0) begin
        access     = 1'b1;
        next_state = RESP;
      end
      RESP: if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt    <= '0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      resp_valid <= 1'b0;
      rd_hold    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          oor_q   <= req_oor;
          idx_q   <= req_idx;
          wdata_q <= req_wdata;
          wmask_q <= req_wmask;
          lat_cnt <= LAT_INIT;
        end
        BUSY: if (lat_cnt != 4'd0) begin
          lat_cnt <= lat_cnt - 4'd1;
        end else begin
          resp_valid <= 1'b1;
          rd_hold    <= ~we_q & ~oor_q;
          err_q      <= oor_q;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          rd_hold    <= 1'b0;
          err_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  ysyx_22050612_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (access & ~oor_q),
    .we    (we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .wmask (wmask_q),
    .rdata (arr_rdata)
  );

  // Array read register is not reset; gating keeps resp_rdata zero outside read responses
  assign resp_rdata = rd_hold ? arr_rdata : '0;
  assign resp_err   = err_q;
  assign req_ready  = (state == IDLE);
endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// Directed bench: instance 0 runs LAT=2, instance 1 runs LAT=1.
module tb_ysyx_22050612_mem_responder;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [1:0][63:0] req_addr, req_wdata, resp_rdata;
  logic [1:0][7:0]  req_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050612_mem_responder #(.LAT(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  ysyx_22050612_mem_responder #(.LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input logic we, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [7:0] m);
    @(negedge clk);
    check_eq("req_ready_idle", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_wmask[d] = m;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d, input int lat, input logic [63:0] exp_rd,
                           input logic exp_err);
    int k = 0;
    while (!resp_valid[d] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("latency", 64'(k), 64'(lat));
    check_eq("resp_rdata", resp_rdata[d], exp_rd);
    check_eq("resp_err", 64'(resp_err[d]), 64'(exp_err));
  endtask

  task automatic ack(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check_eq("post_ack_valid", 64'(resp_valid[d]), 64'd0);
    check_eq("post_ack_rdata", resp_rdata[d], 64'd0);
    check_eq("post_ack_ready", 64'(req_ready[d]), 64'd1);
  endtask

  task automatic do_req(input int d, input int lat, input logic we, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [7:0] m,
                        input logic [63:0] exp_rd, input logic exp_err);
    send(d, we, addr, wd, m);
    wait_resp(d, lat, exp_rd, exp_err);
    ack(d);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; resp_ready = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(resp_valid[0]), 64'd0);
    check_eq("rst_rdata", resp_rdata[0], 64'd0);
    check_eq("rst_err", 64'(resp_err[0]), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready0", 64'(req_ready[0]), 64'd1);
    check_eq("rst_ready1", 64'(req_ready[1]), 64'd1);

    // Full write then read, both latencies
    do_req(0, 2, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0);
    do_req(0, 2, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122334455667788, 1'b0);
    do_req(1, 1, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0);
    do_req(1, 1, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122334455667788, 1'b0);

    // Backpressure with a competing request that must be ignored
    send(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00);
    wait_resp(0, 2, 64'h1122334455667788, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1;
      req_addr[0] = 64'h8000_0010; req_wdata[0] = 64'hDEADBEEFDEADBEEF; req_wmask[0] = 8'hFF;
      check_eq("bp_valid", 64'(resp_valid[0]), 64'd1);
      check_eq("bp_rdata", resp_rdata[0], 64'h1122334455667788);
      check_eq("bp_ready", 64'(req_ready[0]), 64'd0);
    end
    @(negedge clk); req_valid[0] = 1'b0;
    ack(0);
    do_req(0, 2, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122334455667788, 1'b0);

    // Partial write of the top byte, and zero-mask write leaves word unchanged
    do_req(0, 2, 1'b1, 64'h8000_0010, 64'hAB00_0000_0000_0000, 8'h80, 64'd0, 1'b0);
    do_req(0, 2, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0);
    do_req(0, 2, 1'b0, 64'h8000_0017, 64'd0, 8'h00, 64'hAB22334455667788, 1'b0);

    // Reset while a write is in BUSY: array keeps the old value
    do_req(0, 2, 1'b1, 64'h8000_0018, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0);
    send(0, 1'b1, 64'h8000_0018, 64'hCAFEF00DCAFEF00D, 8'hFF);
    rst = 1'b1;
    #1;
    check_eq("busy_rst_valid", 64'(resp_valid[0]), 64'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("busy_rst_ready", 64'(req_ready[0]), 64'd1);
    do_req(0, 2, 1'b0, 64'h8000_0018, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0);

    // Reset while a read response is pending
    send(0, 1'b0, 64'h8000_0018, 64'd0, 8'h00);
    wait_resp(0, 2, 64'h0123456789ABCDEF, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("resp_rst_valid", 64'(resp_valid[0]), 64'd0);
    check_eq("resp_rst_rdata", resp_rdata[0], 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("resp_rst_ready", 64'(req_ready[0]), 64'd1);

    // Just below the window: aliases to the last word unless range-checked
    do_req(0, 2, 1'b1, 64'h8000_1FF8, 64'h5A5A_A5A5_0F0F_F0F0, 8'hFF, 64'd0, 1'b0);
`ifdef MEM_RESP_RANGE_CHK_EN
    do_req(0, 2, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
    do_req(0, 2, 1'b1, 64'h7FFF_FFF8, 64'h1111_1111_1111_1111, 8'hFF, 64'd0, 1'b1);
    do_req(0, 2, 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0);
`else
    do_req(0, 2, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
